// File: rtl/status_led_pkg.sv
// Shared types and constants for the multi-channel status LED driver.
package status_led_pkg;

    localparam int MODE_W  = 2;
    localparam int COUNT_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_COUNT = 2'b11
    } led_mode_e;

    // Per-channel phase FSM; BLINK reuses FLASH_ON/FLASH_OFF and never enters GAP
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FLASH_ON  = 2'd1;
    localparam logic [1:0] ST_FLASH_OFF = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/status_led_channel.sv
// One status LED channel: mode register, ms timer, phase FSM and optional duty.
// Duty ports and register exist only when STATUS_LED_PWM_EN is defined.
module status_led_channel
    import status_led_pkg::*;
#(
    parameter int BLINK_HALF_MS = 250,
    parameter int GAP_MS        = 1000,
    parameter int PWM_BITS      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                wr_en,
    input  logic [MODE_W-1:0]   wr_mode,
    input  logic [COUNT_W-1:0]  wr_count,
`ifdef STATUS_LED_PWM_EN
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
`endif
    output logic                lit,
    output logic                busy
);

    localparam int TW = $clog2(max_int(BLINK_HALF_MS, GAP_MS) + 1);

    led_mode_e          mode_q, mode_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] flash_q, flash_d;
    logic [1:0]         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               phase_end;
    logic               phase_on;

    // Timer compares against the current phase length, then clears (never wraps)
    always_comb begin
        if (state_q == ST_GAP) phase_end = (timer_q == TW'(GAP_MS - 1));
        else                   phase_end = (timer_q == TW'(BLINK_HALF_MS - 1));
    end

    // Next-state: a write always wins over a coincident tick and re-syncs the phase
    always_comb begin
        mode_d  = mode_q;
        count_d = count_q;
        flash_d = flash_q;
        state_d = state_q;
        timer_d = timer_q;
        if (wr_en) begin
            mode_d  = led_mode_e'(wr_mode);
            count_d = wr_count;
            flash_d = COUNT_W'(1);
            timer_d = '0;
            if (wr_mode == MODE_BLINK || (wr_mode == MODE_COUNT && wr_count != '0)) begin
                state_d = ST_FLASH_ON;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (tick && state_q != ST_IDLE) begin
            if (phase_end) begin
                timer_d = '0;
                case (state_q)
                    ST_FLASH_ON:  state_d = ST_FLASH_OFF;
                    ST_FLASH_OFF: begin
                        if (mode_q != MODE_COUNT) begin
                            state_d = ST_FLASH_ON;
                        end else if (flash_q < count_q) begin
                            state_d = ST_FLASH_ON;
                            flash_d = flash_q + 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        state_d = ST_FLASH_ON;
                        flash_d = COUNT_W'(1);
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            count_q <= '0;
            flash_q <= '0;
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            mode_q  <= mode_d;
            count_q <= count_d;
            flash_q <= flash_d;
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign phase_on = (mode_q == MODE_ON) || (state_q == ST_FLASH_ON);
    assign busy     = (state_q != ST_IDLE);

`ifdef STATUS_LED_PWM_EN
    logic [PWM_BITS-1:0] duty_q;

    // Duty latched on each accepted write; resets to full brightness
    always_ff @(posedge clk) begin
        if (!rst_n)     duty_q <= '1;
        else if (wr_en) duty_q <= wr_duty;
    end

    assign lit = phase_on && ((duty_q == '1) || (pwm_cnt < duty_q));
`else
    assign lit = phase_on;
`endif

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED driver top: prescaler, config decode, output registers.
// Optional feature macro: STATUS_LED_PWM_EN (per-channel duty via shared PWM counter).
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int NUM_LEDS      = 2,
    parameter int TICK_DIV      = 50000,
    parameter int BLINK_HALF_MS = 250,
    parameter int GAP_MS        = 1000,
    parameter int PWM_BITS      = 4,
    localparam int CH_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                sysClock,
    input  logic                nReset,
    input  logic                cfgValid,
    output logic                cfgReady,
    input  logic [CH_W-1:0]     cfgChannel,
    input  logic [MODE_W-1:0]   cfgMode,
    input  logic [COUNT_W-1:0]  cfgCount,
    input  logic [PWM_BITS-1:0] cfgDuty,
    output logic                cfgError,
    output logic [NUM_LEDS-1:0] busy,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]    presc_q;
    logic                tick;
    logic                accept;
    logic                chan_ok;
    logic [NUM_LEDS-1:0] lit_vec;
    logic [NUM_LEDS-1:0] busy_vec;

    assign tick    = (presc_q == PRE_W'(TICK_DIV - 1));
    assign accept  = cfgValid && cfgReady;
    assign chan_ok = (int'(cfgChannel) < NUM_LEDS);

    // Free-running 1 ms prescaler shared by every channel
    always_ff @(posedge sysClock) begin
        if (!nReset)   presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + 1'b1;
    end

`ifdef STATUS_LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_q;

    // Free-running PWM counter shared by every channel
    always_ff @(posedge sysClock) begin
        if (!nReset) pwm_q <= '0;
        else         pwm_q <= pwm_q + 1'b1;
    end
`else
    logic unused_duty;
    assign unused_duty = ^cfgDuty;
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        status_led_channel #(
            .BLINK_HALF_MS (BLINK_HALF_MS),
            .GAP_MS        (GAP_MS),
            .PWM_BITS      (PWM_BITS)
        ) u_chan (
            .clk      (sysClock),
            .rst_n    (nReset),
            .tick     (tick),
            .wr_en    (accept && (int'(cfgChannel) == i)),
            .wr_mode  (cfgMode),
            .wr_count (cfgCount),
`ifdef STATUS_LED_PWM_EN
            .wr_duty  (cfgDuty),
            .pwm_cnt  (pwm_q),
`endif
            .lit      (lit_vec[i]),
            .busy     (busy_vec[i])
        );
    end

    // Registered outputs; an out-of-range write only raises a one-cycle error
    always_ff @(posedge sysClock) begin
        if (!nReset) begin
            leds     <= '0;
            busy     <= '0;
            cfgError <= 1'b0;
            cfgReady <= 1'b0;
        end else begin
            leds     <= lit_vec;
            busy     <= busy_vec;
            cfgError <= accept && !chan_ok;
            cfgReady <= 1'b1;
        end
    end

endmodule
